// File: rtl/rr_arbiter4way16_pkg.sv
// Shared definitions for the four-source packet-aware round-robin arbiter:
// source count, index width, FSM encoding, pointer reset value and the
// layout of the registered output beat.
package rr_arbiter4way16_pkg;

    localparam int NUM_SRC = 4;
    localparam int SRC_W   = 2;
    localparam int DATA_W  = 16;

    // ARB scans all sources; LOCKED only serves the source owning the packet.
    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Pointer starts at the last source so source 0 has first priority.
    localparam logic [SRC_W-1:0] PTR_RST = 2'd3;

    // One buffered output beat.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
        logic [SRC_W-1:0]  src;
    } out_beat_t;

endpackage

// File: rtl/rr_arbiter4way16_if.sv
// Bundle of the four source streams and the single merged output stream.
// The arbiter connects through the slave modport; whatever drives the
// sources and consumes the output uses the master modport.
interface rr_arbiter4way16_if;
    import rr_arbiter4way16_pkg::*;

    logic [DATA_W-1:0]  in_data0;
    logic [DATA_W-1:0]  in_data1;
    logic [DATA_W-1:0]  in_data2;
    logic [DATA_W-1:0]  in_data3;
    logic [NUM_SRC-1:0] in_valid;
    logic [NUM_SRC-1:0] in_last;
    logic [NUM_SRC-1:0] in_ready;
    logic [DATA_W-1:0]  out_data;
    logic               out_valid;
    logic               out_last;
    logic [SRC_W-1:0]   out_src;
    logic               out_ready;

    modport master (
        output in_data0, in_data1, in_data2, in_data3, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last, out_src
    );

    modport slave (
        input  in_data0, in_data1, in_data2, in_data3, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last, out_src
    );

endinterface

// File: rtl/rr_arbiter4way16_mux.sv
// Plain 4-way 16-bit multiplexer; the arbiter drives its select with the
// index of the currently granted source.
module Mux16bit4way (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    input  logic [15:0] d,
    input  logic [1:0]  sel,
    output logic [15:0] y
);

    // Route the selected payload to the output.
    always_comb begin
        case (sel)
            2'd0:    y = a;
            2'd1:    y = b;
            2'd2:    y = c;
            default: y = d;
        endcase
    end

endmodule

// File: rtl/rr_arbiter4way16.sv
// Four-source round-robin arbiter with optional packet locking. The winning
// source's beat is steered through the multiplexer into a one-entry output
// register that has its own valid/ready handshake.
module rr_arbiter4way16
    import rr_arbiter4way16_pkg::*;
#(
    parameter int LOCK_PACKETS = 1
) (
    input logic               clk,
    input logic               rst,
    rr_arbiter4way16_if.slave bus
);

    localparam bit LOCK_EN = (LOCK_PACKETS != 0);

    arb_state_t         state;
    logic [SRC_W-1:0]   ptr;
    logic [SRC_W-1:0]   lock_src;
    out_beat_t          out_q;
    logic               out_valid_q;

    logic               load_en;
    logic               grant_found;
    logic [SRC_W-1:0]   grant_idx;
    logic [SRC_W-1:0]   rr_idx;
    logic               rr_found;
    logic               accept;
    logic               sel_last;
    logic [DATA_W-1:0]  mux_data;
    logic [NUM_SRC-1:0] ready_vec;

    // First valid source after ptr, scanning ptr+1 .. ptr+4 (ptr itself last).
    // Returns {found, index}.
    function automatic logic [SRC_W:0] pick_rr(
        input logic [NUM_SRC-1:0] valid,
        input logic [SRC_W-1:0]   start
    );
        logic [SRC_W-1:0] idx;
        pick_rr = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            idx = start + SRC_W'(k);
            if (valid[idx]) begin
                pick_rr = {1'b1, idx};
            end
        end
    endfunction

    // Choose the candidate source: the locked owner, or the rotating winner.
    always_comb begin
        {rr_found, rr_idx} = pick_rr(bus.in_valid, ptr);
        if (state == LOCKED) begin
            grant_idx   = lock_src;
            grant_found = bus.in_valid[lock_src];
        end else begin
            grant_idx   = rr_idx;
            grant_found = rr_found;
        end
    end

    assign load_en  = !out_valid_q || bus.out_ready;
    assign accept   = grant_found && load_en && !rst;
    assign sel_last = bus.in_last[grant_idx];

    // One-hot ready toward the granted source only when its beat is taken.
    always_comb begin
        ready_vec = '0;
        if (accept) begin
            ready_vec[grant_idx] = 1'b1;
        end
    end

    assign bus.in_ready = ready_vec;

    Mux16bit4way u_mux (
        .a   (bus.in_data0),
        .b   (bus.in_data1),
        .c   (bus.in_data2),
        .d   (bus.in_data3),
        .sel (grant_idx),
        .y   (mux_data)
    );

    // Arbitration FSM, pointer and output register advance together on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ARB;
            ptr         <= PTR_RST;
            lock_src    <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_q       <= '{data: mux_data, last: sel_last, src: grant_idx};
            out_valid_q <= 1'b1;
            ptr         <= grant_idx;
            case (state)
                ARB: begin
                    if (LOCK_EN && !sel_last) begin
                        state    <= LOCKED;
                        lock_src <= grant_idx;
                    end
                end
                LOCKED: begin
                    if (sel_last) begin
                        state <= ARB;
                    end
                end
                default: state <= ARB;
            endcase
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_data  = out_q.data;
    assign bus.out_last  = out_q.last;
    assign bus.out_src   = out_q.src;
    assign bus.out_valid = out_valid_q;

endmodule
